// File: rtl/ddr_command_responder_if.sv
// ddr_command_responder_if: DDR command/data bus between controller and part.
// master = controller side, slave = memory side.
interface ddr_command_responder_if;
  logic        sd_CKE;
  logic        sd_CS;
  logic        sd_RAS;
  logic        sd_CAS;
  logic        sd_WE;
  logic [1:0]  sd_BA;
  logic [12:0] sd_A;
  logic [15:0] dq_in;
  logic [15:0] dq_out;
  logic        dq_oe;
  logic        mode_valid;
  logic        err_cmd;
  logic        err_timing;

  modport master (
    output sd_CKE, sd_CS, sd_RAS, sd_CAS, sd_WE,
    output sd_BA, sd_A, dq_in,
    input  dq_out, dq_oe, mode_valid,
    input  err_cmd, err_timing
  );

  modport slave (
    input  sd_CKE, sd_CS, sd_RAS, sd_CAS, sd_WE,
    input  sd_BA, sd_A, dq_in,
    output dq_out, dq_oe, mode_valid,
    output err_cmd, err_timing
  );
endinterface

// File: rtl/ddr_command_responder.sv
// ddr_command_responder: memory-side DDR command model with burst storage.
// Define DDR_RESP_TIMING_CHECK_EN to enable tRCD/tRP/tMRD/tRFC checking.
module ddr_command_responder #(
  parameter int ROW_BITS = 2,
  parameter int COL_BITS = 4,
  parameter int tRCD     = 3,
  parameter int tRP      = 3,
  parameter int tMRD     = 2,
  parameter int tRFC     = 11
) (
  input logic                    clk133_p,
  input logic                    rst,
  ddr_command_responder_if.slave bus
);
  localparam int AW    = 2 + ROW_BITS + COL_BITS;
  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    B_IDLE, B_LAT, B_RD, B_WR
  } burst_e;

  logic [2:0] rcw;
  logic [1:0] ba;
  logic       cmd_on;
  logic       c_lmr, c_ref, c_pre, c_act;
  logic       c_wr, c_rd, c_bst;
  logic       any_act, cl_ok, bl_ok;
  logic       lmr_set, rw_ok, err_n;

  logic [3:0]          act_q;
  logic [ROW_BITS-1:0] row_q [4];
  logic [2:0]          cl_q, bl_last_q;
  logic                mode_q, err_q;

  burst_e              st_q, st_n;
  logic [2:0]          cnt_q, cnt_n;
  logic [2:0]          blen_q, blen_n;
  logic [1:0]          bk_q, bk_n;
  logic [ROW_BITS-1:0] brow_q, brow_n;
  logic [COL_BITS-1:0] bcol_q, bcol_n;
  logic [COL_BITS-1:0] mask, col;
  logic [AW-1:0]       idx;

  logic [15:0] mem [DEPTH];
  logic [15:0] dq_q;
  logic        oe_q;
  logic        unused_ok;

  assign ba     = bus.sd_BA;
  assign rcw    = {bus.sd_RAS, bus.sd_CAS, bus.sd_WE};
  assign cmd_on = bus.sd_CKE & ~bus.sd_CS;

  assign c_lmr = cmd_on & (rcw == 3'b000);
  assign c_ref = cmd_on & (rcw == 3'b001);
  assign c_pre = cmd_on & (rcw == 3'b010);
  assign c_act = cmd_on & (rcw == 3'b011);
  assign c_wr  = cmd_on & (rcw == 3'b100);
  assign c_rd  = cmd_on & (rcw == 3'b101);
  assign c_bst = cmd_on & (rcw == 3'b110);

  assign any_act = |act_q;
  assign cl_ok   = (bus.sd_A[6:4] == 3'd2)
                 | (bus.sd_A[6:4] == 3'd3);
  assign bl_ok   = ~bus.sd_A[2]
                 & (bus.sd_A[1:0] != 2'd0);
  assign lmr_set = c_lmr & ~any_act
                 & (ba == 2'd0) & cl_ok & bl_ok;
  assign rw_ok   = (c_wr | c_rd) & act_q[ba] & mode_q;

  always_comb begin
    err_n = 1'b0;
    unique case (1'b1)
      c_lmr:
        err_n = any_act
              | ((ba == 2'd0) & ~(cl_ok & bl_ok));
      c_act:          err_n = act_q[ba];
      c_ref:          err_n = any_act;
      (c_wr | c_rd):  err_n = ~rw_ok;
      default: ;
    endcase
  end

  always_ff @(posedge clk133_p or posedge rst) begin
    if (rst) begin
      act_q     <= 4'd0;
      cl_q      <= 3'd2;
      bl_last_q <= 3'd1;
      mode_q    <= 1'b0;
      err_q     <= 1'b0;
      for (int i = 0; i < 4; i++)
        row_q[i] <= '0;
    end else begin
      err_q <= err_n;
      if (lmr_set) begin
        cl_q      <= bus.sd_A[6:4];
        bl_last_q <= 3'((4'd1 << bus.sd_A[1:0]) - 4'd1);
        mode_q    <= 1'b1;
      end
      if (c_act & ~act_q[ba]) begin
        act_q[ba] <= 1'b1;
        row_q[ba] <= bus.sd_A[ROW_BITS-1:0];
      end
      if (c_pre) begin
        if (bus.sd_A[10]) act_q     <= 4'd0;
        else              act_q[ba] <= 1'b0;
      end
    end
  end

  // One burst engine: any new READ/WRITE/terminate replaces the old burst
  always_comb begin
    st_n   = st_q;
    cnt_n  = cnt_q;
    blen_n = blen_q;
    bk_n   = bk_q;
    brow_n = brow_q;
    bcol_n = bcol_q;
    unique case (st_q)
      B_LAT: begin
        if (cnt_q == 3'd0) st_n  = B_RD;
        else               cnt_n = cnt_q - 3'd1;
      end
      B_RD, B_WR: begin
        if (cnt_q == blen_q) begin
          st_n  = B_IDLE;
          cnt_n = 3'd0;
        end else begin
          cnt_n = cnt_q + 3'd1;
        end
      end
      default: ;
    endcase
    if (rw_ok) begin
      st_n   = c_rd ? B_LAT : B_WR;
      cnt_n  = c_rd ? cl_q - 3'd2 : 3'd0;
      blen_n = bl_last_q;
      bk_n   = ba;
      brow_n = row_q[ba];
      bcol_n = bus.sd_A[COL_BITS-1:0];
    end else if (c_bst) begin
      st_n  = B_IDLE;
      cnt_n = 3'd0;
    end
  end

  always_ff @(posedge clk133_p or posedge rst) begin
    if (rst) begin
      st_q   <= B_IDLE;
      cnt_q  <= 3'd0;
      blen_q <= 3'd1;
      bk_q   <= 2'd0;
      brow_q <= '0;
      bcol_q <= '0;
    end else begin
      st_q   <= st_n;
      cnt_q  <= cnt_n;
      blen_q <= blen_n;
      bk_q   <= bk_n;
      brow_q <= brow_n;
      bcol_q <= bcol_n;
    end
  end

  // Wrap within the BL-aligned column block
  assign mask = COL_BITS'(blen_q);
  assign col  = (bcol_q & ~mask)
              | ((bcol_q + COL_BITS'(cnt_q)) & mask);
  assign idx  = {bk_q, brow_q, col};

  always_ff @(posedge clk133_p) begin
    if (st_q == B_WR)
      mem[idx] <= bus.dq_in;
  end

  always_ff @(posedge clk133_p or posedge rst) begin
    if (rst) begin
      oe_q <= 1'b0;
      dq_q <= 16'd0;
    end else if (st_q == B_RD) begin
      oe_q <= 1'b1;
      dq_q <= mem[idx];
    end else begin
      oe_q <= 1'b0;
      dq_q <= 16'd0;
    end
  end

  assign bus.dq_out     = dq_q;
  assign bus.dq_oe      = oe_q;
  assign bus.mode_valid = mode_q;
  assign bus.err_cmd    = err_q;
  assign unused_ok      = ^bus.sd_A;

`ifdef DDR_RESP_TIMING_CHECK_EN
  logic [7:0] rcd_q [4];
  logic [7:0] rp_q  [4];
  logic [7:0] mrd_q, rfc_q;
  logic       c_any, viol, tim_q;

  assign c_any = cmd_on & (rcw != 3'b111);
  assign viol  = ((c_wr | c_rd) & (rcd_q[ba] != 8'd0))
               | (c_act & (rp_q[ba] != 8'd0))
               | (c_any & ((mrd_q != 8'd0)
                         | (rfc_q != 8'd0)));

  always_ff @(posedge clk133_p or posedge rst) begin
    if (rst) begin
      tim_q <= 1'b0;
      mrd_q <= 8'd0;
      rfc_q <= 8'd0;
      for (int i = 0; i < 4; i++) begin
        rcd_q[i] <= 8'd0;
        rp_q[i]  <= 8'd0;
      end
    end else begin
      tim_q <= viol;
      if (c_lmr)               mrd_q <= 8'(tMRD - 1);
      else if (mrd_q != 8'd0)  mrd_q <= mrd_q - 8'd1;
      if (c_ref)               rfc_q <= 8'(tRFC - 1);
      else if (rfc_q != 8'd0)  rfc_q <= rfc_q - 8'd1;
      for (int i = 0; i < 4; i++) begin
        if (c_act & ~act_q[i] & (ba == 2'(i)))
          rcd_q[i] <= 8'(tRCD - 1);
        else if (rcd_q[i] != 8'd0)
          rcd_q[i] <= rcd_q[i] - 8'd1;
        if (c_pre & (bus.sd_A[10] | (ba == 2'(i))))
          rp_q[i] <= 8'(tRP - 1);
        else if (rp_q[i] != 8'd0)
          rp_q[i] <= rp_q[i] - 8'd1;
      end
    end
  end

  assign bus.err_timing = tim_q;
`else
  logic unused_tp;
  assign unused_tp      = |(tRCD + tRP + tMRD + tRFC);
  assign bus.err_timing = 1'b0;
`endif
endmodule

// File: tb/tb_ddr_command_responder.sv
// tb_ddr_command_responder: directed test plan plus random commands
// checked against a cycle-indexed schedule model of the DDR part.
module tb_ddr_command_responder;
  localparam int LMR = 0, REF = 1, PRE = 2, ACT = 3;
  localparam int WR = 4, RD = 5, BST = 6, NOP = 7;
  localparam int DESEL = 8, CKELO = 9;
  localparam int NC = 4096;
  localparam int TRCD = 3, TRP = 3, TMRD = 2, TRFC = 11;

  logic clk = 1'b0;
  logic rst;
  always #4 clk = ~clk;

  ddr_command_responder_if bus();

  ddr_command_responder #(
    .ROW_BITS(2), .COL_BITS(4),
    .tRCD(TRCD), .tRP(TRP), .tMRD(TMRD), .tRFC(TRFC)
  ) dut (
    .clk133_p(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk, n_fail, cyc;
  bit mv;
  int cl, bl;
  bit act [4];
  int row [4];
  logic [15:0] mem_m [256];
  bit known [256];
  bit wv [NC];
  bit rv [NC];
  int wa [NC];
  int ra [NC];
  int l_act [4];
  int l_pre [4];
  int l_lmr, l_ref;
  bit e_oe, e_err, e_tim, e_dqk;
  logic [15:0] e_dq;

  task automatic check(input string tag,
                       input logic [15:0] got,
                       input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h",
               tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    mv = 0; cl = 2; bl = 2;
    l_lmr = -1000; l_ref = -1000;
    for (int b = 0; b < 4; b++) begin
      act[b] = 0; row[b] = 0;
      l_act[b] = -1000; l_pre[b] = -1000;
    end
    for (int i = 0; i < NC; i++) begin
      wv[i] = 0; rv[i] = 0;
    end
  endtask

  task automatic clear_future(input int c);
    for (int i = c + 1; i < c + 20 && i < NC; i++) begin
      wv[i] = 0; rv[i] = 0;
    end
  endtask

  task automatic model_edge(input int op,
                            input logic [1:0] ba,
                            input logic [12:0] a,
                            input logic [15:0] d);
    int eff, start, col, adr, s;
    bit anyact;
    e_oe = 0; e_dq = 16'd0; e_dqk = 1;
    e_err = 0; e_tim = 0;
    if (wv[cyc]) begin
      mem_m[wa[cyc]] = d;
      known[wa[cyc]] = 1;
    end
    if (rv[cyc]) begin
      e_oe = 1;
      e_dq = mem_m[ra[cyc]];
      e_dqk = known[ra[cyc]];
    end
    eff = (op > 7) ? NOP : op;
    anyact = act[0] | act[1] | act[2] | act[3];
    if (eff != NOP) begin
      if (cyc - l_lmr < TMRD || cyc - l_ref < TRFC)
        e_tim = 1;
      if ((eff == WR || eff == RD) && cyc - l_act[ba] < TRCD)
        e_tim = 1;
      if (eff == ACT && cyc - l_pre[ba] < TRP)
        e_tim = 1;
    end
    case (eff)
      LMR: begin
        l_lmr = cyc;
        if (anyact) e_err = 1;
        else if (ba == 2'd0) begin
          if ((a[6:4] == 3'd2 || a[6:4] == 3'd3) &&
              a[2:0] >= 3'd1 && a[2:0] <= 3'd3) begin
            cl = int'(a[6:4]);
            bl = 1 << a[2:0];
            mv = 1;
          end else e_err = 1;
        end
      end
      REF: begin
        l_ref = cyc;
        if (anyact) e_err = 1;
      end
      PRE:
        for (int b = 0; b < 4; b++)
          if (a[10] || b == int'(ba)) begin
            act[b] = 0;
            l_pre[b] = cyc;
          end
      ACT:
        if (act[ba]) e_err = 1;
        else begin
          act[ba] = 1;
          row[ba] = int'(a[1:0]);
          l_act[ba] = cyc;
        end
      WR, RD:
        if (!act[ba] || !mv) e_err = 1;
        else begin
          clear_future(cyc);
          start = int'(a[3:0]);
          for (int k = 0; k < bl; k++) begin
            col = (start & ~(bl - 1)) | ((start + k) & (bl - 1));
            adr = int'(ba) * 64 + row[ba] * 16 + col;
            s = (eff == WR) ? cyc + 1 + k : cyc + cl + k;
            if (eff == WR) begin wv[s] = 1; wa[s] = adr; end
            else begin rv[s] = 1; ra[s] = adr; end
          end
        end
      BST: clear_future(cyc);
      default: ;
    endcase
  endtask

  task automatic step(input int op, input logic [1:0] ba,
                      input logic [12:0] a, input logic [15:0] d);
    logic [2:0] rcw;
    rcw = (op > 7) ? 3'($urandom_range(0, 7)) : 3'(op);
    bus.sd_CKE = (op != CKELO);
    bus.sd_CS  = (op == DESEL);
    {bus.sd_RAS, bus.sd_CAS, bus.sd_WE} = rcw;
    bus.sd_BA = ba;
    bus.sd_A  = a;
    bus.dq_in = d;
    @(posedge clk);
    cyc++;
    model_edge(op, ba, a, d);
    #1;
    check("dq_oe", 16'(bus.dq_oe), 16'(e_oe));
    if (e_dqk) check("dq_out", bus.dq_out, e_dq);
    check("err_cmd", 16'(bus.err_cmd), 16'(e_err));
    check("mode_valid", 16'(bus.mode_valid), 16'(mv));
`ifdef DDR_RESP_TIMING_CHECK_EN
    check("err_timing", 16'(bus.err_timing), 16'(e_tim));
`else
    check("err_timing", 16'(bus.err_timing), 16'd0);
`endif
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++)
      step(NOP, 2'd0, 13'd0, 16'($urandom));
  endtask

  task automatic set_idle_inputs();
    bus.sd_CKE = 1'b1; bus.sd_CS = 1'b0;
    bus.sd_RAS = 1'b1; bus.sd_CAS = 1'b1; bus.sd_WE = 1'b1;
    bus.sd_BA = 2'd0; bus.sd_A = 13'd0; bus.dq_in = 16'd0;
  endtask

  task automatic do_reset();
    set_idle_inputs();
    rst = 1'b1;
    #1;
    check("rst_oe", 16'(bus.dq_oe), 16'd0);
    check("rst_dq", bus.dq_out, 16'd0);
    check("rst_mv", 16'(bus.mode_valid), 16'd0);
    check("rst_err", 16'(bus.err_cmd), 16'd0);
    check("rst_tim", 16'(bus.err_timing), 16'd0);
    model_reset();
    @(posedge clk); cyc++;
    @(posedge clk); cyc++;
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int r, op;
    logic [1:0] ba;
    logic [12:0] a;
    n_chk = 0; n_fail = 0; cyc = 0;
    for (int i = 0; i < 256; i++) known[i] = 0;
    model_reset();
    set_idle_inputs();
    rst = 1'b1;
    @(posedge clk); cyc++;
    @(posedge clk); cyc++;
    #1;
    check("rst_oe", 16'(bus.dq_oe), 16'd0);
    check("rst_dq", bus.dq_out, 16'd0);
    check("rst_mv", 16'(bus.mode_valid), 16'd0);
    check("rst_err", 16'(bus.err_cmd), 16'd0);
    check("rst_tim", 16'(bus.err_timing), 16'd0);
    rst = 1'b0;

    // CL=2 BL=2
    step(LMR, 2'd0, 13'h021, 16'd0);
    check("tp_mv", 16'(bus.mode_valid), 16'd1);
    check("tp_lmr_err", 16'(bus.err_cmd), 16'd0);
    nops(2);
    step(ACT, 2'd0, 13'h000, 16'd0);
    nops(3);
    step(WR, 2'd0, 13'h000, 16'd0);
    step(NOP, 2'd0, 13'd0, 16'h3210);
    step(NOP, 2'd0, 13'd0, 16'h7654);
    step(RD, 2'd0, 13'h000, 16'd0);
    step(NOP, 2'd0, 13'd0, 16'd0);
    check("tp_rd_lat", 16'(bus.dq_oe), 16'd0);
    step(NOP, 2'd0, 13'd0, 16'd0);
    check("tp_rd_oe0", 16'(bus.dq_oe), 16'd1);
    check("tp_rd_w0", bus.dq_out, 16'h3210);
    step(NOP, 2'd0, 13'd0, 16'd0);
    check("tp_rd_w1", bus.dq_out, 16'h7654);
    step(NOP, 2'd0, 13'd0, 16'd0);
    check("tp_rd_end", 16'(bus.dq_oe), 16'd0);

    // BL=4, wrap within block
    step(PRE, 2'd0, 13'h400, 16'd0);
    nops(3);
    step(LMR, 2'd0, 13'h022, 16'd0);
    nops(2);
    step(ACT, 2'd0, 13'h000, 16'd0);
    nops(3);
    step(WR, 2'd0, 13'h002, 16'd0);
    for (int k = 1; k <= 4; k++)
      step(NOP, 2'd0, 13'd0, 16'(k));
    step(RD, 2'd0, 13'h000, 16'd0);
    nops(1);
    step(NOP, 2'd0, 13'd0, 16'd0);
    check("tp_wrap0", bus.dq_out, 16'd3);
    step(NOP, 2'd0, 13'd0, 16'd0);
    check("tp_wrap1", bus.dq_out, 16'd4);
    step(NOP, 2'd0, 13'd0, 16'd0);
    check("tp_wrap2", bus.dq_out, 16'd1);
    step(NOP, 2'd0, 13'd0, 16'd0);
    check("tp_wrap3", bus.dq_out, 16'd2);
    nops(2);

    // illegal commands
    step(RD, 2'd1, 13'h000, 16'd0);
    check("tp_rd_idle", 16'(bus.err_cmd), 16'd1);
    step(ACT, 2'd0, 13'h001, 16'd0);
    check("tp_act_act", 16'(bus.err_cmd), 16'd1);
    step(NOP, 2'd0, 13'd0, 16'd0);
    check("tp_err_pulse", 16'(bus.err_cmd), 16'd0);
    check("tp_no_oe", 16'(bus.dq_oe), 16'd0);
    nops(3);

    // tRCD gap of 1 then of 3
    step(ACT, 2'd2, 13'h001, 16'd0);
    step(RD, 2'd2, 13'h000, 16'd0);
`ifdef DDR_RESP_TIMING_CHECK_EN
    check("tp_trcd_bad", 16'(bus.err_timing), 16'd1);
`else
    check("tp_trcd_off", 16'(bus.err_timing), 16'd0);
`endif
    nops(5);
    step(ACT, 2'd3, 13'h002, 16'd0);
    nops(2);
    step(RD, 2'd3, 13'h000, 16'd0);
    check("tp_trcd_ok", 16'(bus.err_timing), 16'd0);
    nops(6);

    // reset mid-burst
    step(RD, 2'd0, 13'h000, 16'd0);
    nops(2);
    check("tp_burst_on", 16'(bus.dq_oe), 16'd1);
    do_reset();
    step(RD, 2'd0, 13'h000, 16'd0);
    check("tp_rd_after_rst", 16'(bus.err_cmd), 16'd1);
    nops(3);

    for (int it = 0; it < 1500; it++) begin
      r  = int'($urandom_range(0, 99));
      ba = 2'($urandom);
      a  = 13'($urandom);
      if (r < 35)      op = NOP;
      else if (r < 40) op = DESEL;
      else if (r < 43) op = CKELO;
      else if (r < 55) op = ACT;
      else if (r < 66) op = WR;
      else if (r < 77) op = RD;
      else if (r < 86) op = PRE;
      else if (r < 92) op = LMR;
      else if (r < 95) op = REF;
      else             op = BST;
      if (op == LMR) begin
        if ($urandom_range(0, 4) != 0)
          a = {6'd0, 3'($urandom_range(2, 3)),
               1'b0, 3'($urandom_range(1, 3))};
        ba = ($urandom_range(0, 3) == 3) ? 2'd1 : 2'd0;
      end
      step(op, ba, a, 16'($urandom));
      if (it == 750) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
